input_route_unit: RTL
=====================

# input_route_unit

Pipelined, parametrised per-VC route computation unit for one RaveNoC router input port. For each accepted flit it computes a one-hot output-port request: head flits are routed by the compiled routing algorithm, and the route is stored in a per-VC routing table for the body and tail flits that follow. Each VC has its own packet state machine, so packets on different VCs can interleave. The unit sits between the input VC buffer and the switch allocator, with a registered valid/ready output stage.

## Interface
- `ROUTER_X_ID`, 0: X coordinate of this router.
- `ROUTER_Y_ID`, 0: Y coordinate of this router.
- `N_VC`, 2: number of virtual channels, 1..8.
- `X_W`, 2: width of the X destination field.
- `Y_W`, 2: width of the Y destination field.
- `ROUTING_MODE`, 0: 0 = X-then-Y, 1 = Y-then-X.
- `clk` in 1: clock; all logic on its rising edge.
- `arst` in 1: reset, synchronous, active-high.
- `flit_valid_i` in 1: input flit valid.
- `flit_ready_o` out 1: unit accepts the flit this cycle.
- `flit_type_i` in 2: flit type; 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL (single-flit packet).
- `flit_vc_i` in $clog2(N_VC) (min 1): VC of the flit.
- `flit_x_dest_i` in X_W: destination X; used on HEAD/HEAD_TAIL only.
- `flit_y_dest_i` in Y_W: destination Y; used on HEAD/HEAD_TAIL only.
- `route_valid_o` out 1: registered route request valid.
- `route_ready_i` in 1: switch allocator grant; completes the handshake.
- `route_vc_o` out $clog2(N_VC): VC of the routed flit.
- `route_port_o` out 5: one-hot request; bit0 NORTH, bit1 SOUTH, bit2 WEST, bit3 EAST, bit4 LOCAL.
- `vc_busy_o` out N_VC: per-VC packet in progress.
- `err_o` out N_VC: sticky per-VC protocol error; constant 0 when error checking is not compiled in.

## Operation
- A flit is accepted when `flit_valid_i && flit_ready_o`.
  - `flit_ready_o = !route_valid_o || route_ready_i`. It is combinational and does not depend on `flit_valid_i`.
- Route computation, ROUTING_MODE 0 (X-then-Y):
  - dest == own coordinates: LOCAL.
  - x_dest != X_ID: x_dest > X_ID gives SOUTH, otherwise NORTH.
  - x_dest == X_ID: y_dest < Y_ID gives WEST, otherwise EAST.
- Route computation, ROUTING_MODE 1 (Y-then-X):
  - dest == own coordinates: LOCAL.
  - y_dest != Y_ID: y_dest > Y_ID gives EAST, otherwise WEST.
  - y_dest == Y_ID: x_dest < X_ID gives NORTH, otherwise SOUTH.
- Comparisons are unsigned. Coordinates are zero-extended to max(X_W, Y_W) before comparison.
- Per-VC routing table: N_VC entries, 3-bit port code (0 N, 1 S, 2 W, 3 E, 4 L). Reset value is NORTH.
- Per-VC state machine, states IDLE and ACTIVE, updated only on acceptance:
  - IDLE + HEAD: write table, go to ACTIVE.
  - IDLE + HEAD_TAIL: write table, stay IDLE.
  - ACTIVE + BODY: read table, stay ACTIVE.
  - ACTIVE + TAIL: read table, go to IDLE.
  - `vc_busy_o[v]` = (state[v] == ACTIVE).
- A HEAD or HEAD_TAIL flit uses its freshly computed route, never the stale table entry.
- Accepted flits load the output register: `route_valid_o` set, `route_port_o` one-hot decoded, `route_vc_o` = `flit_vc_i`.
- The output register clears when `route_ready_i` is high and no new flit is accepted in that cycle.

## Timing
- Latency: a flit accepted in cycle N gives `route_valid_o` in cycle N+1.
- Throughput: 1 flit/cycle while `route_ready_i` stays high.
- Back-pressure: while `route_valid_o && !route_ready_i`, the output register holds its contents stable and `flit_ready_o` is 0.
- Acceptance and handshake in the same cycle: the new flit replaces the output register with no bubble.
- Table write and read in one cycle: a HEAD on VC a and a BODY on VC b never collide, since only one flit arrives per cycle. A TAIL followed immediately by a HEAD on the same VC is legal.
- Reset values: `route_valid_o` = 0, `route_port_o` = 0, `route_vc_o` = 0, `vc_busy_o` = 0, `err_o` = 0. All table entries NORTH, all VCs IDLE.
- Reset asserted mid-packet: everything returns to its reset value on that edge, and any in-flight output request is discarded.

## Configuration
- `RAVENOC_ROUTE_CHECK_EN` defined:
  - BODY/TAIL on an IDLE VC: the flit is accepted and dropped (no output produced), `err_o[v]` is set, and the state is unchanged.
  - HEAD/HEAD_TAIL on an ACTIVE VC: routed normally, the table is overwritten, the state follows the HEAD rules, and `err_o[v]` is set.
  - `err_o` bits clear only on reset.
- `RAVENOC_ROUTE_CHECK_EN` undefined:
  - BODY/TAIL on an IDLE VC are forwarded using the stale table entry (NORTH after reset).
  - HEAD on an ACTIVE VC overwrites silently.
  - `err_o` = 0.

## Test plan
- Router (1,1), mode 0: HEAD to (1,1), (2,1), (0,1), (1,0), (1,3) -> `route_port_o` 10000, 00010, 00001, 00100, 01000, each one cycle after acceptance.
- Router (1,1), mode 1: HEAD to (2,0) -> 00100 (WEST); HEAD to (0,1) -> 00001 (NORTH).
- N_VC=2: HEAD vc0 to SOUTH, HEAD vc1 to EAST, then BODY vc0, BODY vc1, TAIL vc0 -> ports 00010, 01000, 00010, 01000, 00010. Afterwards `vc_busy_o` = 2'b10.
- Back-pressure: `route_ready_i` = 0 for 3 cycles with a flit pending -> output stable, `flit_ready_o` = 0. Ready high -> next flit emitted with no bubble.
- With `RAVENOC_ROUTE_CHECK_EN`: BODY on IDLE vc1 -> no `route_valid_o`, `err_o` = 2'b10. Without the macro: the same flit is forwarded with port 00001 and `err_o` = 0.
- Assert `arst` during an ACTIVE packet with `route_valid_o` = 1 -> next cycle `route_valid_o` = 0 and `vc_busy_o` = 0. A following BODY on that VC routes NORTH with the macro off.

Source files
------------

// File: rtl/input_route_unit_if.sv
// Input-port handshake bundle: flit side (VC buffer -> unit) and route side (unit -> switch allocator).
// Latency: none, wires only.
// Backpressure: flit_ready_o / route_ready_i carry the valid-ready handshakes.
// Ports: flit_* (valid/ready, type, vc, x/y destination), route_* (valid/ready, vc, one-hot port),
//        vc_busy_o (per-VC packet open), err_o (sticky per-VC protocol error).
// Modports: slave = the route unit, master = the upstream/downstream driver (testbench).
interface input_route_unit_if #(
    parameter int N_VC = 2,
    parameter int X_W  = 2,
    parameter int Y_W  = 2
);
    localparam int VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;

    logic              flit_valid_i;
    logic              flit_ready_o;
    logic [1:0]        flit_type_i;
    logic [VC_W-1:0]   flit_vc_i;
    logic [X_W-1:0]    flit_x_dest_i;
    logic [Y_W-1:0]    flit_y_dest_i;
    logic              route_valid_o;
    logic              route_ready_i;
    logic [VC_W-1:0]   route_vc_o;
    logic [4:0]        route_port_o;
    logic [N_VC-1:0]   vc_busy_o;
    logic [N_VC-1:0]   err_o;

    modport slave (
        input  flit_valid_i, flit_type_i, flit_vc_i, flit_x_dest_i, flit_y_dest_i, route_ready_i,
        output flit_ready_o, route_valid_o, route_vc_o, route_port_o, vc_busy_o, err_o
    );

    modport master (
        output flit_valid_i, flit_type_i, flit_vc_i, flit_x_dest_i, flit_y_dest_i, route_ready_i,
        input  flit_ready_o, route_valid_o, route_vc_o, route_port_o, vc_busy_o, err_o
    );
endinterface

// File: rtl/input_route_unit.sv
// Per-VC route computation for one router input port (XY / YX, routing table for body/tail flits).
// Latency: 1 cycle, flit accepted in cycle N shows up on route_valid_o in cycle N+1.
// Backpressure: flit_ready_o = !route_valid_o || route_ready_i; output register holds while stalled.
// Ports: clk, arst (synchronous, active-high), bus (input_route_unit_if.slave).
// Optional: RAVENOC_ROUTE_CHECK_EN compiles in per-VC protocol checking (drop + sticky err_o).
module input_route_unit #(
    parameter int ROUTER_X_ID  = 0,
    parameter int ROUTER_Y_ID  = 0,
    parameter int N_VC         = 2,
    parameter int X_W          = 2,
    parameter int Y_W          = 2,
    parameter int ROUTING_MODE = 0
) (
    input  logic clk,
    input  logic arst,
    input_route_unit_if.slave bus
);
    localparam int VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;
    localparam int C_W  = (X_W > Y_W) ? X_W : Y_W;

    localparam logic [C_W-1:0] OWN_X = C_W'(ROUTER_X_ID);
    localparam logic [C_W-1:0] OWN_Y = C_W'(ROUTER_Y_ID);

    // Port codes held in the routing table
    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_W = 3'd2;
    localparam logic [2:0] P_E = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} vc_state_t;

    vc_state_t        r_state     [N_VC];
    vc_state_t        w_state_nxt [N_VC];
    logic [2:0]       r_table     [N_VC];
    logic             r_route_valid;
    logic [4:0]       r_route_port;
    logic [VC_W-1:0]  r_route_vc;

    logic             w_accept;
    logic             w_head;
    logic             w_drop;
    logic [VC_W-1:0]  w_vc;
    logic [C_W-1:0]   w_x;
    logic [C_W-1:0]   w_y;
    logic [2:0]       w_route_code;
    logic [2:0]       w_code;

    assign w_vc     = bus.flit_vc_i;
    assign w_x      = C_W'(bus.flit_x_dest_i);
    assign w_y      = C_W'(bus.flit_y_dest_i);
    assign w_head   = (bus.flit_type_i == T_HEAD) || (bus.flit_type_i == T_HT);
    assign bus.flit_ready_o = !r_route_valid || bus.route_ready_i;
    assign w_accept = bus.flit_valid_i && bus.flit_ready_o;

    always_comb begin
        w_route_code = P_N;
        if (w_x == OWN_X && w_y == OWN_Y) begin
            w_route_code = P_L;
        end else if (ROUTING_MODE == 0) begin
            if (w_x != OWN_X) w_route_code = (w_x > OWN_X) ? P_S : P_N;
            else              w_route_code = (w_y < OWN_Y) ? P_W : P_E;
        end else begin
            if (w_y != OWN_Y) w_route_code = (w_y > OWN_Y) ? P_E : P_W;
            else              w_route_code = (w_x < OWN_X) ? P_N : P_S;
        end
    end

    // Heads bypass the table so a back-to-back TAIL/HEAD on one VC never sees a stale entry
    assign w_code = w_head ? w_route_code : r_table[w_vc];

`ifdef RAVENOC_ROUTE_CHECK_EN
    logic             w_cur_active;
    logic [N_VC-1:0]  r_err;

    assign w_cur_active = (r_state[w_vc] == ST_ACTIVE);
    // Body/tail with no open packet has no valid route; swallow it
    assign w_drop       = w_accept && !w_head && !w_cur_active;
    assign bus.err_o    = r_err;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_err <= '0;
        end else if (w_accept && (w_head ? w_cur_active : !w_cur_active)) begin
            r_err[w_vc] <= 1'b1;
        end
    end
`else
    assign w_drop    = 1'b0;
    assign bus.err_o = '0;
`endif

    // Per-VC packet state: only the addressed VC can move, and only on acceptance
    always_comb begin
        for (int v = 0; v < N_VC; v++) w_state_nxt[v] = r_state[v];
        if (w_accept && !w_drop) begin
            case (bus.flit_type_i)
                T_HEAD:  w_state_nxt[w_vc] = ST_ACTIVE;
                T_HT:    w_state_nxt[w_vc] = ST_IDLE;
                T_TAIL:  w_state_nxt[w_vc] = ST_IDLE;
                T_BODY:  w_state_nxt[w_vc] = r_state[w_vc];
                default: w_state_nxt[w_vc] = r_state[w_vc];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < N_VC; v++) begin
                r_state[v] <= ST_IDLE;
                r_table[v] <= P_N;
            end
        end else begin
            for (int v = 0; v < N_VC; v++) r_state[v] <= w_state_nxt[v];
            if (w_accept && w_head) r_table[w_vc] <= w_route_code;
        end
    end

    // Output stage: a new flit overwrites in the same cycle the old one is granted
    always_ff @(posedge clk) begin
        if (arst) begin
            r_route_valid <= 1'b0;
            r_route_port  <= '0;
            r_route_vc    <= '0;
        end else if (w_accept && !w_drop) begin
            r_route_valid <= 1'b1;
            r_route_port  <= 5'b00001 << w_code;
            r_route_vc    <= w_vc;
        end else if (bus.route_ready_i) begin
            r_route_valid <= 1'b0;
        end
    end

    assign bus.route_valid_o = r_route_valid;
    assign bus.route_port_o  = r_route_port;
    assign bus.route_vc_o    = r_route_vc;

    for (genvar g = 0; g < N_VC; g++) begin : g_busy
        assign bus.vc_busy_o[g] = (r_state[g] == ST_ACTIVE);
    end
endmodule
